// File: rtl/bus_cycle_sequencer.sv
// ============================================================================
// Module   : bus_cycle_sequencer
// Brief    : PlayBus master FSM issuing setup/strobe/hold cycles per command,
//            with 8-word ROM->RAM block copy and contention abort.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_cycle_sequencer (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       start,
    input  logic [2:0] func,
    input  logic [2:0] address_in,
    input  logic       contend,
    output logic [2:0] address_out,
    output logic       n_ROMO,
    output logic       n_RAMO,
    output logic       n_SWBEN,
    output logic       n_RAMW,
    output logic       LEDLTCH,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_SETUP  = 3'd1;
    localparam logic [2:0] c_S_STROBE = 3'd2;
    localparam logic [2:0] c_S_HOLD   = 3'd3;
    localparam logic [2:0] c_S_DONE   = 3'd4;

    localparam logic [2:0] c_F_NOP   = 3'd0;
    localparam logic [2:0] c_F_BLOCK = 3'd6;
    localparam logic [2:0] c_F_RSVD  = 3'd7;
    localparam logic [2:0] c_LAST_WORD = 3'd7;

    logic [2:0] r_state;
    logic [2:0] r_func;
    logic [2:0] r_addr;
    logic       r_n_romo;
    logic       r_n_ramo;
    logic       r_n_swben;
    logic       r_n_ramw;
    logic       r_ledltch;
    logic       r_busy;
    logic       r_done;
    logic       r_error;
    logic       w_suppress;
    logic       w_led_sink;

    function automatic logic f_src_rom(input logic [2:0] f);
        return (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    endfunction

    function automatic logic f_src_ram(input logic [2:0] f);
        return (f == 3'd2);
    endfunction

    function automatic logic f_src_sw(input logic [2:0] f);
        return (f == 3'd3) || (f == 3'd5);
    endfunction

    // Every transfer code has exactly one sink: the LED latch or the RAM write.
    assign w_led_sink = (r_func == 3'd1) || (r_func == 3'd2) || (r_func == 3'd5);
    assign w_suppress = (r_state == c_S_STROBE) && contend;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= c_S_IDLE;
            r_func    <= c_F_NOP;
            r_addr    <= 3'd0;
            r_n_romo  <= 1'b1;
            r_n_ramo  <= 1'b1;
            r_n_swben <= 1'b1;
            r_n_ramw  <= 1'b1;
            r_ledltch <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_func  <= func;
                        r_error <= 1'b0;
                        if (func == c_F_NOP) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end else if (func == c_F_RSVD) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else begin
                            r_state   <= c_S_SETUP;
                            r_busy    <= 1'b1;
                            r_addr    <= (func == c_F_BLOCK) ? 3'd0 : address_in;
                            r_n_romo  <= ~f_src_rom(func);
                            r_n_ramo  <= ~f_src_ram(func);
                            r_n_swben <= ~f_src_sw(func);
                        end
                    end
                end
                c_S_SETUP: begin
                    r_state   <= c_S_STROBE;
                    r_n_ramw  <= w_led_sink;
                    r_ledltch <= w_led_sink;
                end
                c_S_STROBE: begin
                    r_n_ramw  <= 1'b1;
                    r_ledltch <= 1'b0;
                    if (contend) begin
                        r_state   <= c_S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                        r_n_romo  <= 1'b1;
                        r_n_ramo  <= 1'b1;
                        r_n_swben <= 1'b1;
                    end else begin
                        r_state <= c_S_HOLD;
                    end
                end
                c_S_HOLD: begin
                    if ((r_func == c_F_BLOCK) && (r_addr != c_LAST_WORD)) begin
                        // Source enable stays asserted across words of a block copy.
                        r_addr  <= r_addr + 3'd1;
                        r_state <= c_S_SETUP;
                    end else begin
                        r_state   <= c_S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_n_romo  <= 1'b1;
                        r_n_ramo  <= 1'b1;
                        r_n_swben <= 1'b1;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign address_out = r_addr;
    assign n_ROMO      = r_n_romo;
    assign n_RAMO      = r_n_ramo;
    assign n_SWBEN     = r_n_swben;
    assign n_RAMW      = r_n_ramw | w_suppress;
    assign LEDLTCH     = r_ledltch & ~w_suppress;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule

`default_nettype wire

// File: doc/bus_cycle_sequencer.md
# bus_cycle_sequencer

Multi-cycle bus-master state machine for the PlayBus system. It sits directly upstream of the EPROM, RAM, switch buffer and LED latch, and turns a one-cycle command (function code + address + start) into correctly ordered setup/strobe/hold cycles on the shared 4-bit data bus. It also supports an automatic 8-word ROM-to-RAM block copy and aborts any transfer that hits bus contention.

## Interface
- No parameters; data bus 4 bits, address 3 bits, fixed.
- clk  in  1  system clock, all state changes on rising edge
- n_reset  in  1  asynchronous, active-low reset
- start  in  1  command request, sampled only in IDLE
- func  in  3  function code, captured with start
- address_in  in  3  word address, captured with start
- contend  in  1  bus contention flag from the contention checker
- address_out  out  3  address driven to ROM/RAM
- n_ROMO  out  1  EPROM output enable, active-low
- n_RAMO  out  1  RAM output enable, active-low
- n_SWBEN  out  1  switch buffer enable, active-low
- n_RAMW  out  1  RAM write strobe, active-low
- LEDLTCH  out  1  LED latch load, active-high
- busy  out  1  high from SETUP through HOLD
- done  out  1  one-cycle completion pulse
- error  out  1  sticky fault flag, cleared on next accepted start

## Operation
- Function codes: 0 NOP; 1 ROM->LED (n_ROMO, LEDLTCH); 2 RAM->LED (n_RAMO, LEDLTCH); 3 switch->RAM (n_SWBEN, n_RAMW); 4 ROM->RAM (n_ROMO, n_RAMW); 5 switch->LED (n_SWBEN, LEDLTCH); 6 block copy ROM->RAM, addresses 0..7; 7 reserved.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: all strobes inactive. If start=1, capture func and address_in, clear error, then:
  - func 1-6 -> SETUP. For func 6 the captured address is forced to 0.
  - func 0 -> DONE.
  - func 7 -> DONE with error=1.
- SETUP: address_out is valid. The source enable (n_ROMO, n_RAMO or n_SWBEN) is low. Sink strobes are inactive. Next state is STROBE.
- STROBE: source enable stays low. The sink strobe is asserted: n_RAMW=0 or LEDLTCH=1.
  - If contend=1 in this cycle, the sink strobe is suppressed combinationally (no write or latch occurs), error is set to 1, and the next state is DONE.
  - Otherwise the next state is HOLD.
- HOLD: source enable stays low; sink strobe is inactive.
  - func 1-5 -> DONE.
  - func 6 with address_out<7 -> increment address, go to SETUP.
  - func 6 with address_out=7 -> DONE; the address does not wrap.
- DONE: all strobes inactive, done=1 for exactly one cycle, busy=0, then IDLE.
- At most one source enable and at most one sink strobe are low or high at any time. No strobe is active in IDLE or DONE.
- address_out holds its last value in IDLE and DONE.
- All outputs are registered except the contention-suppressed strobe.

## Timing
- Reset values: n_ROMO=n_RAMO=n_SWBEN=n_RAMW=1, LEDLTCH=0, busy=0, done=0, error=0, address_out=0, state=IDLE.
- Reset asserted mid-transfer returns everything to these values immediately, with no clock required. No partial strobe survives reset.
- Single transfer: start is sampled at edge 0. SETUP occupies cycle 1, STROBE cycle 2, HOLD cycle 3, and done is high in cycle 4. IDLE is reached in cycle 5, when a new start can be accepted.
- Block copy: 8×3 cycles (SETUP/STROBE/HOLD per word), then a 1-cycle DONE, for 25 cycles from acceptance to done. The earliest restart is cycle 26.
- NOP and reserved codes: done is high in cycle 1.
- A start arriving while busy=1 or done=1 is ignored and not queued.
- func and address_in changes after acceptance have no effect.
- Contention abort: STROBE at cycle 2, then done at cycle 3, with no HOLD cycle. A block copy aborts at the failing word; later words are not written.

## Test plan
- Reset mid-STROBE of func 4 → all strobes return to their inactive values immediately, busy=0, done=0, error=0, address_out=0.
- func=1, address_in=5, start pulse → address_out=5; n_ROMO low in cycles 1-3; LEDLTCH high only in cycle 2; done in cycle 4; error=0.
- func=3, address_in=2 → n_SWBEN low in cycles 1-3, n_RAMW low only in cycle 2; start re-asserted in cycle 2 is ignored.
- func=6 → address_out steps 0..7, with n_RAMW pulsing exactly 8 times, once per word in its STROBE cycle; done in cycle 25; address_out stays 7 afterwards.
- func=4 with contend=1 during STROBE → n_RAMW never goes low, error=1, done in cycle 3; the next start with func=0 clears error and done follows in the next cycle.
- func=7 → no strobes, done in cycle 1, error=1 and held until the next accepted start.
